frame_receiver: RTL and testbench

- Serial frame receiver for the LED shift-register protocol (clock, data, latch). It is the receiving end of the same link the lamp driver transmits on.
- Samples an externally generated serial stream and deserializes it into c_bps-bit channel words.
- Writes each word into the framebuffer write port (wen/waddr/wdata).
- On latch, signals frame commit, or frame error if the bit count is wrong.

---
 rtl/lamp_pkg.sv | 26 ++
 rtl/frame_receiver_if.sv | 30 +++
 rtl/frame_receiver_sync_edge.sv | 27 ++
 rtl/frame_receiver.sv | 142 ++++++++++++++
 tb/tb_frame_receiver.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// Shared constants for the LED shift-register link: channel geometry,
// address width derivation and the receiver state encoding.
package lamp_pkg;

   localparam int c_boardchannels  = 32;
   localparam int c_ledboards_dflt = 2;
   localparam int c_bps_dflt       = 12;

   function automatic int channels(input int ledboards);
      return ledboards * c_boardchannels;
   endfunction

   function automatic int addr_w(input int ledboards);
      return $clog2(channels(ledboards));
   endfunction

   localparam int c_channels = channels(c_ledboards_dflt);
   localparam int c_addr_w   = addr_w(c_ledboards_dflt);

   typedef logic [1:0] state_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

endpackage

// File: rtl/frame_receiver_if.sv
// Serial link (sclk/sdi/slat) plus framebuffer write port and frame status.
// The transmitter/bench side is master; the receiver is slave.
interface frame_receiver_if
   import lamp_pkg::*;
#(
   parameter int c_ledboards = c_ledboards_dflt,
   parameter int c_bps       = c_bps_dflt
);
   localparam int c_aw = addr_w(c_ledboards);

   logic            sclk;
   logic            sdi;
   logic            slat;
   logic            wen;
   logic [c_aw-1:0] waddr;
   logic [c_bps-1:0] wdata;
   logic            frame;
   logic            err;

   modport master (
      output sclk, sdi, slat,
      input  wen, waddr, wdata, frame, err
   );

   modport slave (
      input  sclk, sdi, slat,
      output wen, waddr, wdata, frame, err
   );

endinterface

// File: rtl/frame_receiver_sync_edge.sv
// Two-flop synchronizer with a third flop for rising-edge detection; every
// instance has identical depth so data and strobe stay cycle-aligned.
module sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_lvl,
   output logic o_rise
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   assign sync_d = {sync_q[1:0], i_d};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_lvl  = sync_q[1];
   assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/frame_receiver.sv
// Deserializes the LED shift-register stream into channel words, writes them
// to the framebuffer in daisy-chain order and reports frame commit or error.
module frame_receiver
   import lamp_pkg::*;
#(
   parameter int c_ledboards = c_ledboards_dflt,
   parameter int c_bps       = c_bps_dflt
)(
   input  logic                   i_clk,
   input  logic                   i_rst,
   frame_receiver_if.slave        lnk_io
);

   localparam int c_nch = channels(c_ledboards);
   localparam int c_aw  = addr_w(c_ledboards);
   localparam int c_bw  = $clog2(c_bps);
   localparam int c_ww  = $clog2(c_nch + 1);

   localparam logic [c_bw-1:0] c_bit_last = c_bw'(c_bps - 1);
   localparam logic [c_ww-1:0] c_word_full = c_ww'(c_nch);
   localparam logic [c_aw-1:0] c_addr_top = c_aw'(c_nch - 1);

   logic sclk_rise;
   logic sdi_lvl;
   logic slat_rise;
   logic sclk_lvl_unused;
   logic sdi_rise_unused;
   logic slat_lvl_unused;

   sync_edge u_sync_sclk (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (lnk_io.sclk),
      .o_lvl  (sclk_lvl_unused),
      .o_rise (sclk_rise)
   );

   sync_edge u_sync_sdi (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (lnk_io.sdi),
      .o_lvl  (sdi_lvl),
      .o_rise (sdi_rise_unused)
   );

   sync_edge u_sync_slat (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (lnk_io.slat),
      .o_lvl  (slat_lvl_unused),
      .o_rise (slat_rise)
   );

   state_t            state_q, state_d;
   logic [c_bps-1:0]  shift_q, shift_d;
   logic [c_bw-1:0]   bit_q, bit_d;
   logic [c_ww-1:0]   word_q, word_d;
   logic              ovf_q, ovf_d;
   logic              wen_q, wen_d;
   logic [c_aw-1:0]   waddr_q, waddr_d;
   logic [c_bps-1:0]  wdata_q, wdata_d;
   logic              frame_q, frame_d;
   logic              err_q, err_d;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      word_d  = word_q;
      ovf_d   = ovf_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      frame_d = 1'b0;
      err_d   = 1'b0;

      // Latch takes priority over a coincident sclk edge; that bit is dropped.
      if (slat_rise) begin
         frame_d = (state_q == S_FULL) && !ovf_q;
         err_d   = !((state_q == S_FULL) && !ovf_q);
         bit_d   = '0;
         word_d  = '0;
         ovf_d   = 1'b0;
         state_d = S_IDLE;
      end else if (sclk_rise) begin
         if (state_q == S_FULL) begin
            ovf_d = 1'b1;
         end else begin
            shift_d = {shift_q[c_bps-2:0], sdi_lvl};
            state_d = S_RECV;
            if (bit_q == c_bit_last) begin
               bit_d   = '0;
               wen_d   = 1'b1;
               wdata_d = shift_d;
               // First word shifted in belongs to the far end of the chain.
               waddr_d = c_addr_top - word_q[c_aw-1:0];
               if (word_q != c_word_full) begin
                  word_d = word_q + 1'b1;
               end
               if (word_d == c_word_full) begin
                  state_d = S_FULL;
               end
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         ovf_q   <= 1'b0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         ovf_q   <= ovf_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign lnk_io.wen   = wen_q;
   assign lnk_io.waddr = waddr_q;
   assign lnk_io.wdata = wdata_q;
   assign lnk_io.frame = frame_q;
   assign lnk_io.err   = err_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: a frame-level model turns each stimulus
// bit stream into expected framebuffer writes and a commit/error outcome.
module tb_frame_receiver;
   import lamp_pkg::*;

   localparam int NCH   = 64;
   localparam int BPS   = 12;
   localparam int NBITS = NCH * BPS;

   logic clk;
   logic rst;

   frame_receiver_if #(.c_ledboards(2), .c_bps(BPS)) lnk ();

   frame_receiver #(.c_ledboards(2), .c_bps(BPS)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .lnk_io (lnk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit         stim [0:1023];
   logic [5:0] exp_addr [$];
   logic [11:0] exp_data [$];
   bit         exp_end [$];
   int         wr_rd;
   int         end_rd;
   int         n_wen;
   int         n_frame;
   int         n_err;
   int         w0, f0, e0;
   int         errs;
   int         checks;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic compare_cycle();
      if (lnk.wen || lnk.frame || lnk.err)
         chk("wen_pulse_overlap", 32'(lnk.wen & (lnk.frame | lnk.err)), 0);
      if (lnk.wen) begin
         n_wen++;
         if (wr_rd < exp_addr.size()) begin
            chk("waddr", 32'(lnk.waddr), 32'(exp_addr[wr_rd]));
            chk("wdata", 32'(lnk.wdata), 32'(exp_data[wr_rd]));
            wr_rd++;
         end else begin
            chk("wen_unexpected", 32'(lnk.wen), 0);
         end
      end
      if (lnk.frame || lnk.err) begin
         if (lnk.frame) n_frame++;
         if (lnk.err) n_err++;
         if (end_rd < exp_end.size()) begin
            chk("end_kind", 32'({lnk.frame, lnk.err}), exp_end[end_rd] ? 32'd2 : 32'd1);
            end_rd++;
         end else begin
            chk("pulse_unexpected", 32'({lnk.frame, lnk.err}), 0);
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b, input int lo, input int hi);
      lnk.sdi = b;
      wait_cyc(lo);
      lnk.sclk = 1'b1;
      wait_cyc(hi);
      lnk.sclk = 1'b0;
   endtask

   task automatic send_bits(input int n, input int lo, input int hi);
      for (int i = 0; i < n; i++) send_bit(stim[i], lo, hi);
   endtask

   task automatic latch();
      lnk.slat = 1'b1;
      wait_cyc(4);
      lnk.slat = 1'b0;
      wait_cyc(8);
   endtask

   // Frame-level expectation: complete words only, at most NCH of them,
   // commit only when exactly NBITS bits arrived before the latch.
   task automatic model(input int n, input bit with_end);
      int nw;
      logic [11:0] d;
      nw = n / BPS;
      if (nw > NCH) nw = NCH;
      for (int k = 0; k < nw; k++) begin
         d = '0;
         for (int j = 0; j < BPS; j++) d = {d[10:0], stim[k*BPS + j]};
         exp_addr.push_back(6'(NCH - 1 - k));
         exp_data.push_back(d);
      end
      if (with_end) exp_end.push_back(n == NBITS);
   endtask

   task automatic fill_words();
      logic [11:0] w;
      for (int k = 0; k < NCH; k++) begin
         w = 12'h100 + 12'(k);
         for (int j = 0; j < BPS; j++) stim[k*BPS + j] = w[BPS-1-j];
      end
      for (int i = NBITS; i < 1024; i++) stim[i] = 1'b1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) stim[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic begin_test();
      w0 = n_wen;
      f0 = n_frame;
      e0 = n_err;
   endtask

   task automatic end_test(input string name, input int wexp, input int fexp, input int eexp);
      chk({name, ":wen_count"}, 32'(n_wen - w0), 32'(wexp));
      chk({name, ":frame_count"}, 32'(n_frame - f0), 32'(fexp));
      chk({name, ":err_count"}, 32'(n_err - e0), 32'(eexp));
      chk({name, ":writes_drained"}, 32'(wr_rd), 32'(exp_addr.size()));
      chk({name, ":ends_drained"}, 32'(end_rd), 32'(exp_end.size()));
   endtask

   task automatic full_frame(input string name, input int lo, input int hi);
      int base;
      begin_test();
      fill_words();
      base = exp_addr.size();
      model(NBITS, 1'b1);
      chk({name, ":model_first_addr"}, 32'(exp_addr[base]), 32'd63);
      chk({name, ":model_first_data"}, 32'(exp_data[base]), 32'h100);
      chk({name, ":model_last_addr"}, 32'(exp_addr[base+63]), 32'd0);
      chk({name, ":model_last_data"}, 32'(exp_data[base+63]), 32'h13F);
      send_bits(NBITS, lo, hi);
      latch();
      end_test(name, 64, 1, 0);
   endtask

   initial begin
      bit seen;
      int base;
      errs = 0; checks = 0; wr_rd = 0; end_rd = 0;
      n_wen = 0; n_frame = 0; n_err = 0;
      rst = 1'b1;
      lnk.sclk = 1'b0;
      lnk.sdi  = 1'b0;
      lnk.slat = 1'b0;

      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      wait_cyc(3);
      chk("reset:wen", 32'(lnk.wen), 0);
      chk("reset:waddr", 32'(lnk.waddr), 0);
      chk("reset:wdata", 32'(lnk.wdata), 0);
      chk("reset:frame", 32'(lnk.frame), 0);
      chk("reset:err", 32'(lnk.err), 0);
      rst = 1'b0;
      wait_cyc(3);

      full_frame("full", 4, 4);

      // Short frame: two words, 25th bit dropped.
      begin_test();
      fill_words();
      base = exp_addr.size();
      model(25, 1'b1);
      chk("short:model_writes", 32'(exp_addr.size() - base), 32'd2);
      chk("short:model_addr2", 32'(exp_addr[base+1]), 32'd62);
      chk("short:model_data2", 32'(exp_data[base+1]), 32'h101);
      send_bits(25, 3, 3);
      latch();
      end_test("short", 2, 0, 1);
      full_frame("after_short", 3, 3);

      // Overflow: two extra bits beyond a full frame.
      begin_test();
      fill_words();
      model(NBITS + 2, 1'b1);
      send_bits(NBITS + 2, 3, 3);
      latch();
      end_test("overflow", 64, 0, 1);

      // Last sclk edge coincides with the latch edge.
      begin_test();
      fill_words();
      model(NBITS - 1, 1'b1);
      send_bits(NBITS - 1, 3, 3);
      lnk.sdi = stim[NBITS-1];
      wait_cyc(3);
      lnk.sclk = 1'b1;
      lnk.slat = 1'b1;
      wait_cyc(4);
      lnk.sclk = 1'b0;
      lnk.slat = 1'b0;
      wait_cyc(8);
      end_test("simultaneous", 63, 0, 1);

      // Reset lands while the 25th write is on the bus; that write is lost.
      begin_test();
      fill_words();
      model(24 * BPS, 1'b0);
      send_bits(299, 3, 3);
      lnk.sdi = stim[299];
      wait_cyc(3);
      lnk.sclk = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (lnk.wen) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rst_mid:wen_seen", 32'(seen), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid:wen", 32'(lnk.wen), 0);
      chk("rst_mid:frame", 32'(lnk.frame), 0);
      chk("rst_mid:err", 32'(lnk.err), 0);
      chk("rst_mid:waddr", 32'(lnk.waddr), 0);
      lnk.sclk = 1'b0;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(6);
      end_test("rst_mid", 24, 0, 0);
      full_frame("after_rst", 3, 3);

      // Minimum phase timing with random data.
      begin_test();
      fill_random();
      model(NBITS, 1'b1);
      send_bits(NBITS, 3, 3);
      latch();
      end_test("random", 64, 1, 0);

      // Latch with no bits at all.
      begin_test();
      model(0, 1'b1);
      chk("empty:model_end", 32'(exp_end[exp_end.size()-1]), 0);
      latch();
      end_test("empty", 0, 0, 1);

      wait_cyc(4);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
